// File: rtl/snake_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_head_ctrl
// Description : Snake head movement controller. Paces moves with a tick
//               divider, applies direction buttons (one turn per move, no
//               reversal), detects wall collisions and counts growth from
//               apple-eaten rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_head_ctrl #(
  parameter int COORD_W   = 20,
  parameter int STEP      = 16,
  parameter int TICK_DIV  = 3125000,
  parameter int X_MIN     = 144,
  parameter int X_MAX     = 768,
  parameter int Y_MIN     = 48,
  parameter int Y_MAX     = 496,
  parameter int START_X   = 448,
  parameter int START_Y   = 272,
  parameter int LEN_W     = 8,
  parameter int START_LEN = 3,
  parameter int MAX_LEN   = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               is_Eaten,
  output logic [COORD_W-1:0] headX,
  output logic [COORD_W-1:0] headY,
  output logic [1:0]         dir,
  output logic               move_tick,
  output logic [LEN_W-1:0]   length,
  output logic               grow,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]   c_cnt_last  = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0]         c_st_idle   = 2'b00;
  localparam logic [1:0]         c_st_run    = 2'b01;
  localparam logic [1:0]         c_st_dead   = 2'b10;

  localparam logic [1:0]         c_dir_up    = 2'b00;
  localparam logic [1:0]         c_dir_down  = 2'b01;
  localparam logic [1:0]         c_dir_left  = 2'b10;
  localparam logic [1:0]         c_dir_right = 2'b11;

  // Bounds and step are held one bit wider so a move toward 0 is checked
  // before it can wrap.
  localparam logic [COORD_W:0]   c_step      = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   c_x_min     = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0]   c_x_max     = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]   c_y_min     = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0]   c_y_max     = (COORD_W+1)'(Y_MAX);

  localparam logic [COORD_W-1:0] c_start_x   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] c_start_y   = COORD_W'(START_Y);
  localparam logic [LEN_W-1:0]   c_start_len = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0]   c_max_len   = LEN_W'(MAX_LEN);

  logic [1:0]         state_q,     state_d;
  logic [COORD_W-1:0] head_x_q,    head_x_d;
  logic [COORD_W-1:0] head_y_q,    head_y_d;
  logic [1:0]         dir_q,       dir_d;
  logic [1:0]         pend_q,      pend_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [LEN_W-1:0]   len_q,       len_d;
  logic               move_tick_q, move_tick_d;
  logic               grow_q,      grow_d;
  logic               eat_prev_q,  eat_prev_d;

  logic               w_run;
  logic               w_move;
  logic               w_eat_rise;
  logic               w_req_vld;
  logic [1:0]         w_req;
  logic [1:0]         w_pend_smp;
  logic               w_under;
  logic               w_out;
  logic [COORD_W:0]   w_nx;
  logic [COORD_W:0]   w_ny;

  assign w_run      = (state_q == c_st_run);
  assign w_move     = w_run && (cnt_q == c_cnt_last);
  assign w_eat_rise = w_run && is_Eaten && !eat_prev_q;

  // Button priority encode and pending-direction update (reverse requests dropped).
  always_comb begin
    w_req_vld = 1'b1;
    w_req     = c_dir_right;
    if (btn_up)         w_req = c_dir_up;
    else if (btn_down)  w_req = c_dir_down;
    else if (btn_left)  w_req = c_dir_left;
    else if (btn_right) w_req = c_dir_right;
    else                w_req_vld = 1'b0;

    w_pend_smp = pend_q;
    // Up/down and left/right differ only in bit 0, so the reverse is dir ^ 1.
    if (w_run && w_req_vld && (w_req != (dir_q ^ 2'b01))) begin
      w_pend_smp = w_req;
    end
  end

  // Candidate next head position along the direction that would be committed.
  always_comb begin
    w_nx    = {1'b0, head_x_q};
    w_ny    = {1'b0, head_y_q};
    w_under = 1'b0;
    case (w_pend_smp)
      c_dir_up: begin
        w_under = (w_ny < c_step);
        w_ny    = w_ny - c_step;
      end
      c_dir_down: begin
        w_ny    = w_ny + c_step;
      end
      c_dir_left: begin
        w_under = (w_nx < c_step);
        w_nx    = w_nx - c_step;
      end
      default: begin
        w_nx    = w_nx + c_step;
      end
    endcase
    w_out = w_under || (w_nx < c_x_min) || (w_nx > c_x_max) ||
            (w_ny < c_y_min) || (w_ny > c_y_max);
  end

  // Game FSM, tick divider, move commit and length bookkeeping.
  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    dir_d       = dir_q;
    pend_d      = w_pend_smp;
    cnt_d       = cnt_q;
    len_d       = len_q;
    move_tick_d = 1'b0;
    grow_d      = 1'b0;
    eat_prev_d  = is_Eaten;

    case (state_q)
      c_st_run: begin
        cnt_d = w_move ? '0 : cnt_q + 1'b1;
        if (w_move) begin
          move_tick_d = 1'b1;
          dir_d       = w_pend_smp;
          if (w_out) begin
            state_d = c_st_dead;
          end else begin
            head_x_d = w_nx[COORD_W-1:0];
            head_y_d = w_ny[COORD_W-1:0];
          end
        end
        // Eating is independent of the move, so both can land on one edge.
        if (w_eat_rise && (len_q < c_max_len)) begin
          len_d  = len_q + 1'b1;
          grow_d = 1'b1;
        end
      end
      c_st_idle, c_st_dead: begin
        if (start) begin
          state_d  = c_st_run;
          head_x_d = c_start_x;
          head_y_d = c_start_y;
          dir_d    = c_dir_right;
          pend_d   = c_dir_right;
          cnt_d    = '0;
          len_d    = c_start_len;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= c_st_idle;
      head_x_q    <= c_start_x;
      head_y_q    <= c_start_y;
      dir_q       <= c_dir_right;
      pend_q      <= c_dir_right;
      cnt_q       <= '0;
      len_q       <= c_start_len;
      move_tick_q <= 1'b0;
      grow_q      <= 1'b0;
      eat_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      move_tick_q <= move_tick_d;
      grow_q      <= grow_d;
      eat_prev_q  <= eat_prev_d;
    end
  end

  assign headX     = head_x_q;
  assign headY     = head_y_q;
  assign dir       = dir_q;
  assign move_tick = move_tick_q;
  assign length    = len_q;
  assign grow      = grow_q;
  assign game_over = (state_q == c_st_dead);
  assign state     = state_q;

endmodule
`default_nettype wire
